// File: rtl/csla_accum_64_if.sv
// Operand and result handshake bundle for csla_accum_64.
// Latency: none (wires only).
// Backpressure: in_ready gates operand beats, out_ready gates result hand-off.
interface csla_accum_64_if #(parameter int CNT_W = 8);
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_data;
   logic             in_sub;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_sub, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );

   modport slave (
      input  in_valid, in_data, in_sub, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/csla_accum_64.sv
// 64-bit carry-select adder built from 4-bit blocks with precomputed carry-in 0/1 sums.
// Latency: purely combinational.
// Backpressure: none.
module csla_64 (
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic        i_cin,
   output logic [63:0] o_sum,
   output logic        o_cout
);
   logic [16:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < 16; g++) begin : g_blk
      logic [4:0] w_s0;
      logic [4:0] w_s1;
      assign w_s0 = {1'b0, i_a[4*g +: 4]} + {1'b0, i_b[4*g +: 4]};
      assign w_s1 = w_s0 + 5'd1;
      // The incoming block carry only selects between the two ready sums.
      assign o_sum[4*g +: 4] = w_c[g] ? w_s1[3:0] : w_s0[3:0];
      assign w_c[g+1]        = w_c[g] ? w_s1[4]   : w_s0[4];
   end

   assign o_cout = w_c[16];
endmodule

// Framed add/subtract accumulator feeding off csla_64; reports sum, sticky ovf and beat count.
// Latency: result valid the cycle after the edge that accepts the last beat.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
module csla_accum_64 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   csla_accum_64_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic             r_live;
   logic [63:0]      r_acc;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_accept;
   logic             w_release;
   logic [63:0]      w_base;
   logic [63:0]      w_b;
   logic [63:0]      w_sum;
   logic             w_cout;
   logic             w_flag;

   // Handshake outputs decoded from state; r_live keeps in_ready low until the first edge out of reset.
   always_comb begin
      w_in_ready  = r_live && (r_state != S_HOLD);
      w_out_valid = (r_state == S_HOLD);
   end

   assign w_accept  = bus.in_valid && w_in_ready;
   assign w_release = w_out_valid && bus.out_ready;

   // First beat of a frame starts from zero so a stale acc can never leak in.
   assign w_base = (r_state == S_IDLE) ? 64'd0 : r_acc;
   assign w_b    = bus.in_sub ? ~bus.in_data : bus.in_data;

   csla_64 u_add (
      .i_a    (w_base),
      .i_b    (w_b),
      .i_cin  (bus.in_sub),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Subtraction borrows exactly when the two's-complement add produces no carry.
   assign w_flag = bus.in_sub ? ~w_cout : w_cout;

   // Next-state selection for the frame sequencer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = bus.in_last ? S_HOLD : S_ACCUM;
         S_ACCUM: if (w_accept && bus.in_last) w_next = S_HOLD;
         S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register and post-reset enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   // Accumulator, sticky flag and saturating count; cleared when the result is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= 64'd0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_sum;
         if (r_state == S_IDLE) begin
            r_ovf <= w_flag;
            r_cnt <= CNT_ONE;
         end else begin
            r_ovf <= r_ovf | w_flag;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
         end
      end else if (w_release) begin
         r_acc <= 64'd0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_sum   = r_acc;
   assign bus.out_ovf   = r_ovf;
   assign bus.out_count = r_cnt;
endmodule

// File: tb/tb_csla_accum_64.sv
// Directed bench for csla_accum_64 with a 2-bit beat counter.
// Latency: checks result one cycle after the accepting edge.
// Backpressure: exercises held results with out_ready low and in_valid high.
module tb_csla_accum_64;
   localparam int CNT_W = 2;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   csla_accum_64_if #(.CNT_W(CNT_W)) bus ();

   csla_accum_64 #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents one beat across the next rising edge.
   task automatic beat(input logic [63:0] d, input logic s, input logic l);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sub   = s;
      bus.in_last  = l;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sub   = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = 64'd0;
   endtask

   task automatic chk_res(input string tag, input logic [63:0] s, input logic o, input logic [63:0] c);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_ready"}, bus.in_ready, 0);
      chk({tag, "_sum"},   bus.out_sum, s);
      chk({tag, "_ovf"},   bus.out_ovf, o);
      chk({tag, "_count"}, bus.out_count, c);
   endtask

   task automatic take(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_idle_valid"}, bus.out_valid, 0);
      chk({tag, "_idle_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 64'd0;
      bus.in_sub    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum", bus.out_sum, 0);
      chk("rst_ovf", bus.out_ovf, 0);
      chk("rst_count", bus.out_count, 0);
      rst_n = 1'b1;
      #1 chk("rel_in_ready_before_edge", bus.in_ready, 0);
      @(negedge clk);
      chk("rel_in_ready_after_edge", bus.in_ready, 1);

      // Single beat
      beat(64'h5, 1'b0, 1'b1);
      chk_res("single", 64'h5, 1'b0, 1);
      take("single");
      chk("single_cleared_sum", bus.out_sum, 0);

      // Three-beat frame with a subtract on the last beat
      beat(64'h10, 1'b0, 1'b0);
      chk("three_mid_valid", bus.out_valid, 0);
      chk("three_mid_ready", bus.in_ready, 1);
      beat(64'h20, 1'b0, 1'b0);
      beat(64'h08, 1'b1, 1'b1);
      chk_res("three", 64'h28, 1'b0, 3);
      take("three");

      // Unsigned overflow
      beat(ALL1, 1'b0, 1'b0);
      beat(64'h2, 1'b0, 1'b1);
      chk_res("ovf", 64'h1, 1'b1, 2);
      take("ovf");

      // Subtract as the first beat borrows from zero
      beat(64'h1, 1'b1, 1'b1);
      chk_res("subfirst", ALL1, 1'b1, 1);
      take("subfirst");

      // Underflow, then hold it under backpressure with a pending beat
      beat(64'h1, 1'b0, 1'b0);
      beat(64'h2, 1'b1, 1'b1);
      chk_res("unf", ALL1, 1'b1, 2);
      bus.in_valid = 1'b1;
      bus.in_data  = 64'h99;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready", bus.in_ready, 0);
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_sum", bus.out_sum, ALL1);
         chk("bp_ovf", bus.out_ovf, 1);
         chk("bp_count", bus.out_count, 2);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = 64'd0;
      take("bp");
      beat(64'h3, 1'b0, 1'b1);
      chk_res("after_bp", 64'h3, 1'b0, 1);
      take("after_bp");

      // Saturating count with a bubble inside the frame
      beat(64'h1, 1'b0, 1'b0);
      beat(64'h1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("bubble_valid", bus.out_valid, 0);
      chk("bubble_ready", bus.in_ready, 1);
      beat(64'h1, 1'b0, 1'b0);
      beat(64'h1, 1'b0, 1'b0);
      beat(64'h1, 1'b0, 1'b1);
      chk_res("sat", 64'h5, 1'b0, 3);
      take("sat");

      // Reset mid-frame
      beat(64'h4, 1'b0, 1'b0);
      beat(64'h4, 1'b0, 1'b0);
      chk("pre_rst_sum", bus.out_sum, 64'h8);
      rst_n = 1'b0;
      #1;
      chk("midrst_sum", bus.out_sum, 0);
      chk("midrst_count", bus.out_count, 0);
      chk("midrst_ready", bus.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_rel_ready", bus.in_ready, 1);

      // Reset while holding a result
      beat(64'h9, 1'b1, 1'b1);
      chk_res("hold_pre_rst", ALL1 - 64'h8, 1'b1, 1);
      rst_n = 1'b0;
      #1;
      chk("holdrst_valid", bus.out_valid, 0);
      chk("holdrst_sum", bus.out_sum, 0);
      chk("holdrst_ovf", bus.out_ovf, 0);
      chk("holdrst_count", bus.out_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat(64'h7, 1'b0, 1'b1);
      chk_res("post_rst", 64'h7, 1'b0, 1);
      take("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/csla_accum_64.md
Name: csla_accum_64

Overview:
- Sequential accumulator stage directly downstream of the 64-bit carry-select adder, csla_64.
- Takes a framed stream of 64-bit operands over a valid/ready handshake.
- Adds or subtracts each operand into a 64-bit running register through one csla_64 instance.
- At frame end it presents the final sum, an unsigned overflow/underflow flag and a beat count over a second valid/ready handshake.

Parameters:
- CNT_W, 8, width of the beat counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  64  operand.
- in_sub  input  1  1 = subtract in_data from acc; 0 = add.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  64  final accumulated value, mod 2^64.
- out_ovf  output  1  sticky unsigned overflow/underflow over the frame.
- out_count  output  CNT_W  number of beats in the frame (saturating).

Behaviour:
- Reset: the one clock is clk. Reset is rst_n, asynchronous, active-low. While rst_n=0:
  - state=IDLE, acc=0, ovf=0, cnt=0
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0
  - in_ready rises on the first clk edge after rst_n deasserts.
- Accept: a beat is taken when in_valid && in_ready at a rising edge.
- States and transitions:
  - IDLE: in_ready=1, out_valid=0. An accepted beat loads acc with the result computed from base 0, sets cnt=1 and ovf from that beat, then goes to ACCUM. If in_last is also set, it goes to HOLD instead.
  - ACCUM: in_ready=1. An accepted beat updates acc from base acc, sets cnt=cnt+1 (saturating) and ovf|=beat flag. A beat with in_last goes to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_sum/out_ovf/out_count reflect acc/ovf/cnt and stay stable while out_ready=0. With out_ready=1 at an edge: clear acc, ovf and cnt, and return to IDLE.
- Arithmetic, one csla_64 instance, combinational between registers:
  - Operand a = base, which is 0 in IDLE and acc otherwise.
  - Add: b = in_data, cin = 0. The beat flag is cout (carry out).
  - Sub: b = ~in_data, cin = 1. The beat flag is ~cout (borrow).
  - Result width is 64; wrap-around is mod 2^64.
- Latency: a 1-beat frame accepted at edge N gives out_valid=1 after edge N, i.e. visible in cycle N+1. A K-beat frame with no bubbles gives out_valid after the edge that accepts the last beat.
- There is no back-to-back overlap: at least one cycle with in_ready=0 (HOLD) separates frames. A new frame starts only after HOLD exits.
- in_valid=0 in ACCUM: hold all state; no timeout.
- Saturation: at cnt = 2^CNT_W-1, further beats leave cnt unchanged. This does not affect acc or ovf.
- in_sub and in_last are sampled only on accepted beats. Inputs while in_ready=0 are ignored.
- Reset mid-frame or mid-HOLD: immediate return to the reset values above. The pending result is discarded.
- Outputs are registered: out_sum, out_ovf and out_count come from registers, not from the adder.

Test Plan:
- Single beat: in_data=0x0000_0000_0000_0005, add, in_last=1 → next cycle out_valid=1, out_sum=5, out_ovf=0, out_count=1. out_ready=1 → IDLE, in_ready=1.
- Three-beat frame: +0x10, +0x20, −0x08 (in_sub=1 on the last beat) → out_sum=0x28, out_ovf=0, out_count=3.
- Overflow: +0xFFFF_FFFF_FFFF_FFFF, then +0x2 with last → out_sum=0x1, out_ovf=1. Underflow: +0x1, then −0x2 with last → out_sum=0xFFFF_FFFF_FFFF_FFFF, out_ovf=1.
- Backpressure: after the frame completes, hold out_ready=0 for 5 cycles while driving in_valid=1 → in_ready stays 0, outputs stay stable, and the extra beat is not consumed. out_ready=1 → the next frame starts from acc=0.
- Saturation (CNT_W=2): a 5-beat frame of +1 → out_sum=5, out_count=3.
- Reset: assert rst_n=0 mid-frame (after 2 beats) and while in HOLD → outputs go to 0 immediately. The next frame of +7 with last → out_sum=7, out_count=1.
